// File: rtl/pc_seq_pkg.sv
// Shared types and default parameters for the PC sequencer and its next-PC selector.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam int unsigned XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
    localparam int unsigned PC_INC_DEF       = 4;

endpackage

// File: rtl/pc_seq_next_sel.sv
// pc_next_sel: combinational priority mux for next_pc (boot > trap > redirect > increment).
// With ALIGN_CHECK_EN a misaligned redirect becomes a trap; otherwise the low target bits are cleared.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
    parameter int unsigned     PC_INC       = PC_INC_DEF
) (
    input  logic            boot_i,
    input  logic            trap_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            align_trap_o
);

    always_comb begin
        align_trap_o = 1'b0;
        // Increment wraps naturally in XLEN bits.
        next_pc_o    = pc_i + XLEN'(PC_INC);
        if (boot_i) begin
            next_pc_o = RESET_VECTOR;
        end else if (trap_i) begin
            next_pc_o = TRAP_VECTOR;
        end else if (redirect_i) begin
`ifdef ALIGN_CHECK_EN
            if (target_i[1:0] != 2'b00) begin
                next_pc_o    = TRAP_VECTOR;
                align_trap_o = 1'b1;
            end else begin
                next_pc_o = target_i;
            end
`else
            next_pc_o = target_i & ~XLEN'(3);
`endif
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side controller driving pc_write/next_pc, instruction fetch and decode handoff.
// Optional feature macro ALIGN_CHECK_EN: misaligned branch targets trap and set a sticky misalign flag.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
    parameter int unsigned     PC_INC       = PC_INC_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc,
    output logic            pc_write,
    output logic [XLEN-1:0] next_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap_req,
    output logic [XLEN-1:0] epc,
    output logic            misalign
);

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            boot, trap_acc, hshake, pc_write_raw, align_trap, launch;
    logic [XLEN-1:0] sel_pc;

    assign boot         = (state_q == BOOT);
    assign trap_acc     = trap_req && !boot;
    assign hshake       = (state_q == ISSUE) && instr_ready && !stall;
    assign pc_write_raw = boot || trap_acc || hshake;

    pc_next_sel #(
        .XLEN        (XLEN),
        .RESET_VECTOR(RESET_VECTOR),
        .TRAP_VECTOR (TRAP_VECTOR),
        .PC_INC      (PC_INC)
    ) u_next_sel (
        .boot_i      (boot),
        .trap_i      (trap_acc),
        .redirect_i  (hshake && branch_taken),
        .target_i    (branch_target),
        .pc_i        (pc),
        .next_pc_o   (sel_pc),
        .align_trap_o(align_trap)
    );

    // Held low while reset is asserted even though the state already reads BOOT.
    assign pc_write    = reset_n && pc_write_raw;
    assign next_pc     = sel_pc;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == ISSUE);
    assign epc         = epc_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        epc_d   = epc_q;
        launch  = 1'b0;

        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (trap_acc)      state_d = imem_ack ? FETCH : FLUSH;
                else if (imem_ack) state_d = ISSUE;
            end
            ISSUE: if (trap_acc || hshake) state_d = FETCH;
            FLUSH: if (imem_ack) state_d = FETCH;
        endcase

        if (trap_acc || align_trap) epc_d = pc;

        // A new request starts on every entry into FETCH; a trap in FETCH without ack keeps
        // the outstanding request alive at its old address until the memory answers.
        launch = (state_d == FETCH) && ((state_q != FETCH) || imem_ack);
        if (launch) begin
            req_d  = 1'b1;
            addr_d = pc_write_raw ? sel_pc : pc;
        end else if (imem_ack) begin
            req_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            req_q   <= 1'b0;
            addr_q  <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            epc_q   <= epc_d;
        end
    end

`ifdef ALIGN_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        mis_q <= 1'b0;
        else if (align_trap) mis_q <= 1'b1;
    end

    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: transaction-level model plus directed literal checkpoints.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_V = 32'h0000_0000;
    localparam logic [31:0] TRAP_V  = 32'h0000_0100;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc = 32'hDEAD_BEE0;
    logic        pc_write;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap_req;
    logic [31:0] epc;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    // Model of the fetch side as transactions in flight.
    bit          m_booted, m_req, m_instr, m_discard, m_mis;
    logic [31:0] m_addr, m_epc;

    logic        last_pw, last_valid;
    logic [31:0] last_np;

    pc_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc           (pc),
        .pc_write     (pc_write),
        .next_pc      (next_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .trap_req     (trap_req),
        .epc          (epc),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External program counter register.
    always @(posedge clk) if (pc_write) pc <= next_pc;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock cycle: inputs are already set; compare, advance the model, move to next negedge.
    task automatic cyc();
        logic        exp_pw, hs, mis_br;
        logic [31:0] exp_np;
        #1;
        last_pw    = pc_write;
        last_np    = next_pc;
        last_valid = instr_valid;
        if (!reset_n) begin
            chk("rst_pc_write", pc_write, 0);
            chk("rst_next_pc", next_pc, RESET_V);
            chk("rst_imem_req", imem_req, 0);
            chk("rst_imem_addr", imem_addr, 0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_epc", epc, 0);
            chk("rst_misalign", misalign, 0);
            m_booted = 0; m_req = 0; m_instr = 0; m_discard = 0; m_mis = 0;
            m_addr = '0; m_epc = '0;
        end else begin
            hs     = m_booted && !trap_req && m_instr && instr_ready && !stall;
            mis_br = 1'b0;
            exp_np = '0;
            if (!m_booted) begin
                exp_pw = 1'b1; exp_np = RESET_V;
            end else if (trap_req) begin
                exp_pw = 1'b1; exp_np = TRAP_V;
            end else if (hs) begin
                exp_pw = 1'b1;
                if (!branch_taken) exp_np = pc + 32'd4;
`ifdef ALIGN_CHECK_EN
                else if (branch_target[1:0] != 2'b00) begin
                    exp_np = TRAP_V; mis_br = 1'b1;
                end
`endif
                else exp_np = branch_target & 32'hFFFF_FFFC;
            end else begin
                exp_pw = 1'b0;
            end
            chk("pc_write", pc_write, exp_pw);
            if (exp_pw) chk("next_pc", next_pc, exp_np);
            chk("instr_valid", instr_valid, m_instr);
            chk("imem_req", imem_req, m_req);
            if (m_req) chk("imem_addr", imem_addr, m_addr);
            chk("epc", epc, m_epc);
            chk("misalign", misalign, m_mis);

            if (!m_booted) begin
                m_booted = 1; m_req = 1; m_addr = exp_np;
            end else if (trap_req || mis_br) begin
                m_epc = pc;
                if (mis_br) m_mis = 1;
                if (m_instr) begin
                    m_instr = 0; m_req = 1; m_addr = exp_np;
                end else if (imem_ack) begin
                    m_req = 1; m_addr = exp_np; m_discard = 0;
                end else begin
                    m_discard = 1;
                end
            end else if (hs) begin
                m_instr = 0; m_req = 1; m_addr = exp_np;
            end else if (m_req && imem_ack) begin
                if (m_discard) begin
                    m_discard = 0; m_addr = pc;
                end else begin
                    m_req = 0; m_instr = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    // Answer the outstanding fetch on the lat-th cycle.
    task automatic do_fetch(input int lat);
        imem_ack = 1'b0;
        repeat (lat - 1) cyc();
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
    endtask

    task automatic handshake(input logic br, input logic [31:0] tgt);
        instr_ready = 1'b1; branch_taken = br; branch_target = tgt;
        cyc();
        instr_ready = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0; trap_req = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        reset_n = 1'b1;

        // Boot
        cyc();
        chk("boot_pc_write", last_pw, 1);
        chk("boot_next_pc", last_np, 32'h0);
        chk("boot_req", imem_req, 1);
        chk("boot_addr", imem_addr, 32'h0);

        // Sequential run up to pc=0x40
        for (int i = 0; i < 16; i++) begin
            do_fetch(2);
            handshake(1'b0, 32'h0);
            if (i < 3) chk("seq_next_pc", last_np, 32'(4 * (i + 1)));
        end
        chk("pc_before_branch", pc, 32'h40);

        // Branch
        do_fetch(1);
        handshake(1'b1, 32'h200);
        chk("branch_next_pc", last_np, 32'h200);
        chk("branch_fetch_addr", imem_addr, 32'h200);

        // Stall for 5 cycles
        do_fetch(2);
        stall = 1'b1; instr_ready = 1'b1;
        repeat (5) begin
            cyc();
            chk("stall_pc_write", last_pw, 0);
            chk("stall_valid", last_valid, 1);
        end
        stall = 1'b0;
        cyc();
        instr_ready = 1'b0;
        chk("stall_release_np", last_np, 32'h204);

        // Trap mid-fetch, ack three cycles later
        trap_req = 1'b1;
        cyc();
        trap_req = 1'b0;
        chk("trap_pc_write", last_pw, 1);
        chk("trap_next_pc", last_np, TRAP_V);
        chk("trap_epc", epc, 32'h204);
        chk("flush_req", imem_req, 1);
        chk("flush_addr", imem_addr, 32'h204);
        cyc();
        cyc();
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        chk("flush_discard", instr_valid, 0);
        chk("refetch_req", imem_req, 1);
        chk("refetch_addr", imem_addr, TRAP_V);

        // Wrap-around
        do_fetch(1);
        handshake(1'b1, 32'hFFFF_FFFC);
        do_fetch(1);
        handshake(1'b0, 32'h0);
        chk("wrap_next_pc", last_np, 32'h0);

        // Misaligned target
        do_fetch(1);
        handshake(1'b1, 32'h202);
`ifdef ALIGN_CHECK_EN
        chk("align_next_pc", last_np, TRAP_V);
        chk("align_misalign", misalign, 1);
        chk("align_epc", epc, 32'h0);
`else
        chk("align_next_pc", last_np, 32'h200);
        chk("align_misalign", misalign, 0);
`endif

        // Trap beats a simultaneous branch
        do_fetch(1);
        trap_req = 1'b1;
        handshake(1'b1, 32'h300);
        trap_req = 1'b0;
        chk("trap_vs_branch_np", last_np, TRAP_V);

        // Asynchronous reset during an outstanding fetch
        chk("pre_reset_req", imem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_req", imem_req, 0);
        chk("async_reset_valid", instr_valid, 0);
        @(negedge clk);
        cyc();
        reset_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            stall        = ($urandom_range(0, 3) == 0);
            instr_ready  = ($urandom_range(0, 3) != 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       branch_target = $urandom;
                1:       branch_target = 32'hFFFF_FFFC;
                default: branch_target = $urandom & 32'hFFFF_FFFC;
            endcase
            trap_req = !trap_req && ($urandom_range(0, 24) == 0);
            imem_ack = imem_req && ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
